// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM state, lookahead group size and generate/propagate pair type
package cla_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int GROUP = 4;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
endpackage

// File: rtl/cla_group4.sv
// cla_group4: 4-bit carry-lookahead group (g/p/cin in; carries c[4:1], group generate/propagate out)
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP-1:0] g,
  input  logic [GROUP-1:0] p,
  input  logic             cin,
  output logic [GROUP:1]   c,
  output logic             grp_g,
  output logic             grp_p
);
  always_comb begin
    grp_g = g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | (&p[3:1]) & g[0];
    grp_p = &p;
    c[1]  = g[0] | p[0] & cin;
    c[2]  = g[1] | p[1] & g[0] | p[1] & p[0] & cin;
    c[3]  = g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | (&p[2:0]) & cin;
    c[4]  = grp_g | grp_p & cin;
  end
endmodule

// File: rtl/cla_serial_adder.sv
// cla_serial_adder: valid/ready multi-cycle a+b+cin adder, CHUNK bits per cycle via 4-bit lookahead groups; sum/cout/ovf held until out_ready
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int NG = CHUNK / GROUP;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic carry, last;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CHUNK-1:0] a_s, b_s, g, p;
  logic [CHUNK:1] c;
  logic [NG:0] gc;
  logic [NG-1:0] grp_g, grp_p;
  assign a_s = a_r[int'(idx)*CHUNK +: CHUNK];
  assign b_s = b_r[int'(idx)*CHUNK +: CHUNK];
  assign g = a_s & b_s;
  assign p = a_s ^ b_s;
  assign gc[0] = carry;
  assign last = idx == IW'(NSLICE - 1);
  for (genvar j = 0; j < NG; j++) begin : g_grp
    cla_group4 u_grp (
      .g(g[j*GROUP +: GROUP]),
      .p(p[j*GROUP +: GROUP]),
      .cin(gc[j]),
      .c(c[j*GROUP+1 +: GROUP]),
      .grp_g(grp_g[j]),
      .grp_p(grp_p[j])
    );
    assign gc[j+1] = grp_g[j] | grp_p[j] & gc[j];
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      {a_r, b_r, sum, idx, carry, cout, ovf} <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r   <= a;
      b_r   <= b;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[int'(idx)*CHUNK +: CHUNK] <= p ^ {c[CHUNK-1:1], carry};
      carry <= gc[NG];
      idx   <= idx + 1'b1;
      if (last) begin
        cout <= c[CHUNK];
        ovf  <= c[CHUNK-1] ^ c[CHUNK];
      end
    end
endmodule

// File: tb/tb_cla_serial_adder.sv
// tb_cla_serial_adder: directed vectors on a 64/16 adder plus random ops on a 16/16 adder
module tb_cla_serial_adder;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic v64 = 0, r64, ov64, or64 = 0, ci64 = 0, co64, of64;
  logic [63:0] a64 = 0, b64 = 0, s64;
  logic v16 = 0, r16, ov16, or16 = 0, ci16 = 0, co16, of16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  int n_chk = 0, n_pass = 0;
  cla_serial_adder #(.WIDTH(64), .CHUNK(16)) d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(r64), .a(a64), .b(b64), .cin(ci64),
    .out_valid(ov64), .out_ready(or64), .sum(s64), .cout(co64), .ovf(of64)
  );
  cla_serial_adder #(.WIDTH(16), .CHUNK(16)) d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(r16), .a(a16), .b(b16), .cin(ci16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic start64(input logic [63:0] a, input logic [63:0] b, input logic c, output int lat);
    @(negedge clk);
    check("in_ready_idle", r64, 1);
    a64 = a; b64 = b; ci64 = c; v64 = 1;
    @(posedge clk);
    #1 v64 = 0;
    lat = 0;
    while (!ov64 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic take64;
    @(negedge clk) or64 = 1;
    @(posedge clk);
    #1 or64 = 0;
  endtask
  logic [63:0] va [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0,
                          64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF};
  logic [63:0] vb [6] = '{64'h1, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,
                          64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0000, 64'h1};
  logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [63:0] vs [6] = '{64'h0, 64'h8000_0000_0000_0000, 64'h0,
                          64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0000_0001_0000_0001};
  logic        vco [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        vof [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  initial begin
    int lat;
    logic [15:0] ra, rb;
    logic rc, rovf;
    logic [16:0] e;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", r64, 1);
    check("rst_out_valid", ov64, 0);
    check("rst_sum", s64, 0);
    check("rst_cout", co64, 0);
    check("rst_ovf", of64, 0);
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      start64(va[i], vb[i], vc[i], lat);
      check($sformatf("lat_%0d", i), lat, 4);
      check($sformatf("sum_%0d", i), s64, vs[i]);
      check($sformatf("cout_%0d", i), co64, vco[i]);
      check($sformatf("ovf_%0d", i), of64, vof[i]);
      take64;
      check($sformatf("after_take_%0d", i), {r64, ov64}, 2'b10);
    end
    start64(va[1], vb[1], vc[1], lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v64 = 1; a64 = 64'h1234; b64 = 64'h5678; or64 = 0;
      check("bp_valid", ov64, 1);
      check("bp_sum", s64, vs[1]);
      check("bp_in_ready", r64, 0);
    end
    v64 = 0;
    take64;
    check("bp_taken", {r64, ov64}, 2'b10);
    check("bp_sum_kept", s64, vs[1]);
    @(negedge clk);
    a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h1; ci64 = 0; v64 = 1;
    @(posedge clk);
    #1 v64 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 0;
    @(posedge clk);
    #1;
    check("mid_rst_in_ready", r64, 1);
    check("mid_rst_out_valid", ov64, 0);
    check("mid_rst_sum", s64, 0);
    @(negedge clk) rst_n = 1;
    start64(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1, lat);
    check("fresh_lat", lat, 4);
    check("fresh_sum", s64, 64'hD);
    check("fresh_cout", co64, 0);
    take64;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 16'hFFFF; rb = 16'h0; rc = 1; end
      if (i == 1) begin ra = 16'h8000; rb = 16'hFFFF; rc = 0; end
      e = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      rovf = (ra[15] == rb[15]) && (e[15] != ra[15]);
      @(negedge clk);
      a16 = ra; b16 = rb; ci16 = rc; v16 = 1;
      @(posedge clk);
      #1 v16 = 0;
      lat = 0;
      while (!ov16 && lat < 20) begin
        @(posedge clk);
        #1 lat++;
      end
      check("rnd16", {lat[7:0], co16, of16, s16}, {8'd1, e[16], rovf, e[15:0]});
      @(negedge clk) or16 = 1;
      @(posedge clk);
      #1 or16 = 0;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
